spwm_gate_gen: RTL

Sinusoidal PWM gate generator: consumes the 12-bit offset sine sample stream from the sine LUT stage and compares it against an internal symmetric triangular carrier. It produces a complementary high-side/low-side gate pair with programmable dead time for one inverter leg. The reference is sampled once per carrier period at the valley (symmetric regular sampling). It sits between the sine LUT and the leg's gate-driver pins.

---
 rtl/spwm_gate_gen_if.sv | 19 +
 rtl/spwm_gate_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/spwm_gate_gen_if.sv
// Signal bundle between the sine LUT stage, the SPWM gate generator and the leg's gate pins.
interface spwm_gate_gen_if;
   logic        enable;
   logic [11:0] sine_in;
   logic [11:0] carrier;
   logic        sync;
   logic        gate_h;
   logic        gate_l;

   modport master (
      output enable, sine_in,
      input  carrier, sync, gate_h, gate_l
   );

   modport slave (
      input  enable, sine_in,
      output carrier, sync, gate_h, gate_l
   );
endinterface

// File: rtl/spwm_gate_gen.sv
// Regular-sampled SPWM: triangle carrier vs valley-latched sine, complementary
// gate pair with dead time for one inverter leg.
module spwm_gate_gen #(
   parameter int CARRIER_MAX = 1639,
   parameter int DEAD_TIME   = 20
) (
   input  logic            clk_in,
   input  logic            rst_n,
   spwm_gate_gen_if.slave  bus
);

   localparam logic [11:0] CMAX    = 12'(CARRIER_MAX);
   localparam logic [7:0]  DT_LAST = 8'(DEAD_TIME - 1);

   typedef enum logic [1:0] {S_OFF, S_DT, S_HIGH, S_LOW} state_t;

   state_t      state, state_nx;
   logic [7:0]  dt_cnt, dt_cnt_nx;
   logic [11:0] car_q, ref_q;
   logic        up_q, raw_q, sync_q;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         car_q  <= '0;
         up_q   <= 1'b1;
         ref_q  <= '0;
         raw_q  <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         // Turn around at both ends without repeating the end value.
         if (up_q) begin
            if (car_q == CMAX) begin
               car_q <= CMAX - 12'd1;
               up_q  <= 1'b0;
            end else begin
               car_q <= car_q + 12'd1;
            end
         end else begin
            if (car_q == 12'd0) begin
               car_q <= 12'd1;
               up_q  <= 1'b1;
            end else begin
               car_q <= car_q - 12'd1;
            end
         end

         if (car_q == 12'd0)
            ref_q <= (bus.sine_in > CMAX) ? CMAX : bus.sine_in;

         raw_q  <= (ref_q > car_q);
         // Only a descending 1 -> 0 step is a valley; the reset valley is not.
         sync_q <= !up_q && (car_q == 12'd1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state  <= S_OFF;
         dt_cnt <= '0;
      end else begin
         state  <= state_nx;
         dt_cnt <= dt_cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      dt_cnt_nx = dt_cnt;
      if (!bus.enable) begin
         state_nx  = S_OFF;
         dt_cnt_nx = '0;
      end else begin
         case (state)
            S_OFF: begin
               state_nx  = S_DT;
               dt_cnt_nx = '0;
            end
            S_DT: begin
               // Target follows raw_q at exit; raw toggles inside DT do not restart the count.
               if (dt_cnt == DT_LAST) begin
                  state_nx  = raw_q ? S_HIGH : S_LOW;
                  dt_cnt_nx = '0;
               end else begin
                  dt_cnt_nx = dt_cnt + 8'd1;
               end
            end
            S_HIGH: begin
               if (!raw_q) begin
                  state_nx  = S_DT;
                  dt_cnt_nx = '0;
               end
            end
            S_LOW: begin
               if (raw_q) begin
                  state_nx  = S_DT;
                  dt_cnt_nx = '0;
               end
            end
            default: begin
               state_nx  = S_OFF;
               dt_cnt_nx = '0;
            end
         endcase
      end
   end

   assign bus.carrier = car_q;
   assign bus.sync    = sync_q;
   assign bus.gate_h  = (state == S_HIGH);
   assign bus.gate_l  = (state == S_LOW);

endmodule
